find_max_sequencer: RTL

//  Job-level controller for the find_MAX datapath. Accepts a job (pair count + FU instruction), buffers

---
 rtl/find_max_pkg.sv | 26 ++
 rtl/seq_op_fifo.sv | 49 ++++
 rtl/find_max_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/find_max_pkg.sv
// Shared types and constants for the find_MAX job sequencer: FSM state encoding,
// FU instruction codes and default widths.
package find_max_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int TMO_CYC_DEF = 64;
    localparam int INSTR_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } fms_state_e;

    // FU instruction codes; the sequencer forwards them untouched.
    localparam logic [INSTR_W-1:0] FU_MAX_U   = 3'd0;
    localparam logic [INSTR_W-1:0] FU_MAX_S   = 3'd1;
    localparam logic [INSTR_W-1:0] FU_MIN_U   = 3'd2;
    localparam logic [INSTR_W-1:0] FU_MIN_S   = 3'd3;
    localparam logic [INSTR_W-1:0] FU_MAX_ABS = 3'd4;

endpackage

// File: rtl/seq_op_fifo.sv
// Synchronous operand-pair FIFO for the find_MAX sequencer. Wrap-bit pointers give
// full/empty without a counter; the head word is read combinationally.
module seq_op_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage has no reset: entries are only visible once written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) mem_q[gi] <= wdata;
        end
    end

endmodule

// File: rtl/find_max_sequencer.sv
// Job-level controller driving the find_MAX datapath from a buffered operand stream.
// Optional finish watchdog and err_timeout port enabled by defining FMS_TIMEOUT_EN.
module find_max_sequencer
    import find_max_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [CNT_W-1:0]   job_count,
    input  logic [INSTR_W-1:0] job_instr,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    output logic               fm_start,
    output logic               fm_valid,
    output logic [DATA_W-1:0]  fm_data_a,
    output logic [DATA_W-1:0]  fm_data_b,
    output logic               fm_one_left,
    output logic [INSTR_W-1:0] fm_instruction,
    input  logic [DATA_W-1:0]  fm_maximum,
    input  logic               fm_finish,
    output logic               res_valid,
    output logic [DATA_W-1:0]  res_max,
    output logic               busy
`ifdef FMS_TIMEOUT_EN
    ,
    output logic               err_timeout
`endif
);

    fms_state_e         state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  data_a_q, data_a_d;
    logic [DATA_W-1:0]  data_b_q, data_b_d;
    logic [DATA_W-1:0]  res_max_q, res_max_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [2*DATA_W-1:0] fifo_rdata;
    logic [DATA_W-1:0]   head_a;
    logic [DATA_W-1:0]   head_b;

`ifdef FMS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`else
    logic unused_tmo_cyc;
    assign unused_tmo_cyc = ^TMO_CYC;
`endif

    seq_op_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (op_valid),
        .pop   (fifo_pop),
        .wdata ({op_a, op_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_a = fifo_rdata[2*DATA_W-1:DATA_W];
    assign head_b = fifo_rdata[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            instr_q   <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            res_max_q <= '0;
`ifdef FMS_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            instr_q   <= instr_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            res_max_q <= res_max_d;
`ifdef FMS_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        instr_d   = instr_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        res_max_d = res_max_q;
        fifo_pop  = 1'b0;
`ifdef FMS_TIMEOUT_EN
        tmo_d     = '0;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    rem_d   = job_count;
                    instr_d = job_instr;
`ifdef FMS_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    if (job_count == '0) begin
                        res_max_d = '0;
                        state_d   = ST_RESP;
                    end else begin
                        state_d   = ST_START;
                    end
                end
            end
            ST_START: state_d = ST_STREAM;
            ST_STREAM: begin
                // An empty FIFO simply produces a bubble; the job waits for operands.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_a_d = head_a;
                    data_b_d = head_b;
                    if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
                    if (rem_q <= CNT_W'(1)) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fm_finish) begin
                    res_max_d = fm_maximum;
                    state_d   = ST_RESP;
                end
`ifdef FMS_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                    res_max_d = '0;
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign job_ready      = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign op_ready       = ~fifo_full;
    assign fm_start       = (state_q == ST_START);
    assign fm_valid       = fifo_pop;
    assign fm_data_a      = fifo_pop ? head_a : data_a_q;
    assign fm_data_b      = fifo_pop ? head_b : data_b_q;
    // one_left latches high once the final pair is due and stays up through WAIT.
    assign fm_one_left    = (state_q == ST_WAIT) ||
                            (((state_q == ST_START) || (state_q == ST_STREAM)) &&
                             (rem_q == CNT_W'(1)));
    assign fm_instruction = instr_q;
    assign res_valid      = (state_q == ST_RESP);
    assign res_max        = res_max_q;
`ifdef FMS_TIMEOUT_EN
    assign err_timeout    = err_q;
`endif

endmodule
